// File: rtl/secded_stream_decoder.sv
// secded_stream_decoder: Hamming SECDED decoder for a stream of codewords, with optional error counters.
// Latency: 2 cycles from input acceptance to out_valid (stage 1 = syndrome, stage 2 = correction).
// Backpressure: out_ready low with out_valid high freezes both stages and drops in_ready in the same cycle.
//
// Ports:
//   clock, reset_L             single clock, synchronous active-low reset
//   in_code/in_valid/in_ready  received codeword and its handshake
//   out_data/out_code          corrected data and corrected codeword
//   out_syndrome               raw syndrome of the received word
//   out_err1/out_err2          corrected single error / uncorrectable error
//   out_valid/out_ready        output handshake
//   cnt_clear, cnt_err1/2      error counters; only built when SECDED_ERR_CNT_EN is defined,
//                              otherwise the counts are constant 0 and cnt_clear is ignored
//
// Codeword layout: bit 0 is overall even parity, power-of-two indices are Hamming check
// bits, and the remaining indices (ascending) carry data[0]..data[DATA_W-1].

module secded_stream_decoder #(
  parameter int DATA_W = 8,
  parameter int PAR_W  = 4,
  parameter int CNT_W  = 16,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clock,
  input  logic              reset_L,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CODE_W-1:0] out_code,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_err1,
  output logic              out_err2,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  cnt_err1,
  output logic [CNT_W-1:0]  cnt_err2
);

  // Mask of codeword positions 1..CODE_W-1 whose index has bit i set.
  function automatic logic [CODE_W-1:0] syn_mask(input int i);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int k = 1; k < CODE_W; k++) begin
      if (((k >> i) & 1) == 1) m = m | (CODE_W'(1) << k);
    end
    return m;
  endfunction

  // Codeword index carrying data bit j (j-th non-power-of-two index above 0).
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int k = 1; k < CODE_W; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (cnt == j) pos = k;
        cnt++;
      end
    end
    return pos;
  endfunction

  // ---------------------------------------------------------------------------
  // Syndrome and overall parity of the incoming word (registered into stage 1)
  // ---------------------------------------------------------------------------
  logic [PAR_W-1:0] syn_in;
  logic             pf_in;

  for (genvar i = 0; i < PAR_W; i++) begin : g_syn
    localparam logic [CODE_W-1:0] MASK = syn_mask(i);
    assign syn_in[i] = ^(in_code & MASK);
  end

  assign pf_in = ^in_code;

  // One global advance enable: the whole pipe moves unless the output is stalled.
  // Holding stage 1 whenever stage 2 holds keeps ordering trivially intact.
  logic advance;
  assign in_ready = !(out_valid && !out_ready);
  assign advance  = in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: received codeword, syndrome, parity fail
  // ---------------------------------------------------------------------------
  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_pf;

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_pf    <= 1'b0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_syn  <= syn_in;
        s1_pf   <= pf_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Classification and correction of the stage-1 word
  // ---------------------------------------------------------------------------
  logic              syn_in_range;
  logic              err1_c;
  logic              err2_c;
  logic [CODE_W-1:0] flip_mask;
  logic [CODE_W-1:0] fix_code;
  logic [DATA_W-1:0] fix_data;

  // Syndromes at or beyond CODE_W point outside the codeword, so they can only
  // come from a multi-bit error even when overall parity looks like a single flip.
  assign syn_in_range = (32'(s1_syn) < CODE_W);

  always_comb begin
    err1_c    = 1'b0;
    err2_c    = 1'b0;
    flip_mask = '0;
    if (s1_pf) begin
      if (syn_in_range) begin
        // Syndrome 0 with parity fail means the parity bit itself flipped.
        err1_c    = 1'b1;
        flip_mask = CODE_W'(1) << s1_syn;
      end else begin
        err2_c = 1'b1;
      end
    end else if (s1_syn != '0) begin
      err2_c = 1'b1;
    end
  end

  assign fix_code = s1_code ^ flip_mask;

  for (genvar j = 0; j < DATA_W; j++) begin : g_data
    assign fix_data[j] = fix_code[data_pos(j)];
  end

  // ---------------------------------------------------------------------------
  // Stage 2: corrected outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_code     <= '0;
      out_syndrome <= '0;
      out_err1     <= 1'b0;
      out_err2     <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= fix_data;
        out_code     <= fix_code;
        out_syndrome <= s1_syn;
        out_err1     <= err1_c;
        out_err2     <= err2_c;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error counters
  // ---------------------------------------------------------------------------
`ifdef SECDED_ERR_CNT_EN
  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  // Clear has priority over a coincident transfer; counts saturate at all-ones.
  always_ff @(posedge clock) begin
    if (!reset_L || cnt_clear) begin
      cnt_err1 <= '0;
      cnt_err2 <= '0;
    end else begin
      if (out_xfer && out_err1 && (cnt_err1 != '1)) cnt_err1 <= cnt_err1 + CNT_W'(1);
      if (out_xfer && out_err2 && (cnt_err2 != '1)) cnt_err2 <= cnt_err2 + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;
  assign cnt_err1 = '0;
  assign cnt_err2 = '0;
`endif

endmodule

// File: tb/tb_secded_stream_decoder.sv
// tb_secded_stream_decoder: directed-vector bench for the SECDED stream decoder.
// Drives and samples 1 time unit after each rising edge.
// Counter expectations depend on whether SECDED_ERR_CNT_EN is defined.

module tb_secded_stream_decoder;

  logic        clock;
  logic        reset_L;
  logic [12:0] in_code;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic [12:0] out_code;
  logic [3:0]  out_syndrome;
  logic        out_err1;
  logic        out_err2;
  logic        out_valid;
  logic        out_ready;
  logic        cnt_clear;
  logic [1:0]  cnt_err1;
  logic [1:0]  cnt_err2;

  int checks;
  int errors;

  secded_stream_decoder #(
    .DATA_W(8),
    .PAR_W (4),
    .CNT_W (2)
  ) dut (
    .clock       (clock),
    .reset_L     (reset_L),
    .in_code     (in_code),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_code    (out_code),
    .out_syndrome(out_syndrome),
    .out_err1    (out_err1),
    .out_err2    (out_err2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cnt_clear   (cnt_clear),
    .cnt_err1    (cnt_err1),
    .cnt_err2    (cnt_err2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_L   = 1'b0;
    in_code   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clear = 1'b0;
    cyc();
    cyc();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_data !== 8'h00 || out_code !== 13'h0000 || out_syndrome !== 4'h0) begin
      errors++;
      $display("FAIL reset_fields: data=%h code=%h syn=%h required 0", out_data, out_code, out_syndrome);
    end
    checks++;
    if (out_err1 !== 1'b0 || out_err2 !== 1'b0 || cnt_err1 !== 2'd0 || cnt_err2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_flags: e1=%b e2=%b c1=%0d c2=%0d required 0", out_err1, out_err2, cnt_err1, cnt_err2);
    end
    reset_L = 1'b1;
    cyc();
  endtask

  task automatic test_decode();
    logic [12:0] vin   [7];
    logic [12:0] vcode [7];
    logic [7:0]  vdata [7];
    logic [3:0]  vsyn  [7];
    logic        ve1   [7];
    logic        ve2   [7];
    // clean A5
    vin[0] = 13'h144E; vcode[0] = 13'h144E; vdata[0] = 8'hA5; vsyn[0] = 4'd0;  ve1[0] = 0; ve2[0] = 0;
    // bit 6 flipped
    vin[1] = 13'h140E; vcode[1] = 13'h144E; vdata[1] = 8'hA5; vsyn[1] = 4'd6;  ve1[1] = 1; ve2[1] = 0;
    // overall parity bit flipped
    vin[2] = 13'h144F; vcode[2] = 13'h144E; vdata[2] = 8'hA5; vsyn[2] = 4'd0;  ve1[2] = 1; ve2[2] = 0;
    // bits 3 and 5 flipped: double error, data left uncorrected
    vin[3] = 13'h1466; vcode[3] = 13'h1466; vdata[3] = 8'hA6; vsyn[3] = 4'd6;  ve1[3] = 0; ve2[3] = 1;
    // bits 1,2,12 flipped: syndrome 15 out of range
    vin[4] = 13'h0448; vcode[4] = 13'h0448; vdata[4] = 8'h25; vsyn[4] = 4'd15; ve1[4] = 0; ve2[4] = 1;
    // clean FF with bit 12 flipped: highest correctable index
    vin[5] = 13'h0EEE; vcode[5] = 13'h1EEE; vdata[5] = 8'hFF; vsyn[5] = 4'd12; ve1[5] = 1; ve2[5] = 0;
    // bits 1,4,8 flipped: syndrome 13 = CODE_W, odd parity, still uncorrectable
    vin[6] = 13'h155C; vcode[6] = 13'h155C; vdata[6] = 8'hA5; vsyn[6] = 4'd13; ve1[6] = 0; ve2[6] = 1;
    out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      in_valid = 1'b1;
      in_code  = vin[v];
      cyc();
      in_valid = 1'b0;
      cyc();
      checks++;
      if (out_valid !== 1'b1 || out_code !== vcode[v] || out_data !== vdata[v]) begin
        errors++;
        $display("FAIL decode_%0d_word: valid=%b code=%h data=%h required 1 code=%h data=%h",
                 v, out_valid, out_code, out_data, vcode[v], vdata[v]);
      end
      checks++;
      if (out_syndrome !== vsyn[v] || out_err1 !== ve1[v] || out_err2 !== ve2[v]) begin
        errors++;
        $display("FAIL decode_%0d_flags: syn=%0d e1=%b e2=%b required syn=%0d e1=%b e2=%b",
                 v, out_syndrome, out_err1, out_err2, vsyn[v], ve1[v], ve2[v]);
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] words    [4];
    logic [12:0] exp_code [4];
    logic [7:0]  exp_data [4];
    logic        exp_e1   [4];
    logic [12:0] held;
    logic        xin;
    logic        xout;
    int sent;
    int rcv;
    int last_c;
    words[0] = 13'h144E; exp_code[0] = 13'h144E; exp_data[0] = 8'hA5; exp_e1[0] = 0;
    words[1] = 13'h1EEE; exp_code[1] = 13'h1EEE; exp_data[1] = 8'hFF; exp_e1[1] = 0;
    words[2] = 13'h000F; exp_code[2] = 13'h000F; exp_data[2] = 8'h01; exp_e1[2] = 0;
    words[3] = 13'h144F; exp_code[3] = 13'h144E; exp_data[3] = 8'hA5; exp_e1[3] = 1;
    sent   = 0;
    rcv    = 0;
    last_c = -1;
    held   = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 4);
      if (sent < 4) in_code = words[sent];
      else in_code = '0;
      #1;
      if (c >= 3 && c <= 5) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_c%0d: in_ready=%b out_valid=%b required 0/1", c, in_ready, out_valid);
        end
        if (c == 3) held = out_code;
        else begin
          checks++;
          if (out_code !== held) begin
            errors++;
            $display("FAIL stall_hold_c%0d: code=%h required %h", c, out_code, held);
          end
        end
      end
      xin  = in_valid && in_ready;
      xout = out_valid && out_ready;
      if (xout) begin
        checks++;
        if (rcv >= 4) begin
          errors++;
          $display("FAIL stream_extra: unexpected word code=%h", out_code);
        end else if (out_code !== exp_code[rcv] || out_data !== exp_data[rcv] || out_err1 !== exp_e1[rcv]) begin
          errors++;
          $display("FAIL stream_word_%0d: code=%h data=%h e1=%b required code=%h data=%h e1=%b",
                   rcv, out_code, out_data, out_err1, exp_code[rcv], exp_data[rcv], exp_e1[rcv]);
        end
        rcv++;
        last_c = c;
      end
      @(posedge clock);
      #1;
      if (xin) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rcv != 4 || last_c != 8) begin
      errors++;
      $display("FAIL stream_count: words=%0d last_cycle=%0d required 4 and 8", rcv, last_c);
    end
  endtask

  task automatic test_counters();
    out_ready = 1'b1;
    cnt_clear = 1'b1;
    cyc();
    cnt_clear = 1'b0;
    checks++;
    if (cnt_err1 !== 2'd0 || cnt_err2 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_clear: c1=%0d c2=%0d required 0/0", cnt_err1, cnt_err2);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_code  = 13'h140E;
      cyc();
    end
    in_valid = 1'b1;
    in_code  = 13'h1466;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    cyc();
`ifdef SECDED_ERR_CNT_EN
    checks++;
    if (cnt_err1 !== 2'd3 || cnt_err2 !== 2'd1) begin
      errors++;
      $display("FAIL cnt_saturate: c1=%0d c2=%0d required 3/1", cnt_err1, cnt_err2);
    end
    cnt_clear = 1'b1;
    cyc();
    cnt_clear = 1'b0;
    in_valid  = 1'b1;
    in_code   = 13'h140E;
    cyc();
    in_valid = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b1 || out_err1 !== 1'b1) begin
      errors++;
      $display("FAIL cnt_pre: out_valid=%b e1=%b required 1/1", out_valid, out_err1);
    end
    cnt_clear = 1'b1;
    cyc();
    cnt_clear = 1'b0;
    checks++;
    if (cnt_err1 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_clear_wins: c1=%0d required 0", cnt_err1);
    end
    // leave one uncorrectable count behind for the mid-stream reset to clear
    in_valid = 1'b1;
    in_code  = 13'h0448;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if (cnt_err2 !== 2'd1) begin
      errors++;
      $display("FAIL cnt_err2_inc: c2=%0d required 1", cnt_err2);
    end
`else
    checks++;
    if (cnt_err1 !== 2'd0 || cnt_err2 !== 2'd0) begin
      errors++;
      $display("FAIL cnt_disabled: c1=%0d c2=%0d required 0/0", cnt_err1, cnt_err2);
    end
`endif
  endtask

  task automatic test_reset_midstream();
    logic seen;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 13'h144E;
    cyc();
    in_code = 13'h1466;
    cyc();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: out_valid=%b required 1", out_valid);
    end
    reset_L = 1'b0;
    cyc();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt_err1 !== 2'd0 || cnt_err2 !== 2'd0) begin
      errors++;
      $display("FAIL midreset_state: out_valid=%b in_ready=%b c1=%0d c2=%0d required 0/1/0/0",
               out_valid, in_ready, cnt_err1, cnt_err2);
    end
    reset_L   = 1'b1;
    out_ready = 1'b1;
    seen      = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      cyc();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flush: out_valid seen=%b required 0", seen);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_counters();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
